immediate_encoder: RTL and testbench

//  Multi-cycle inverse of the immediate extender: takes a 32-bit constant plus an imm_src

---
 rtl/immediate_encoder_pkg.sv | 23 ++
 rtl/immediate_encoder_rotate_left_32.sv | 16 +
 rtl/immediate_encoder.sv | 125 ++++++++++++
 tb/tb_immediate_encoder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/immediate_encoder_pkg.sv
// Shared constants for the immediate encoder and the immediate extender.
// The imm_src encodings must stay identical to the ones the extender decodes.
package immediate_encoder_pkg;

    localparam logic [1:0] IMM_SRC_DP    = 2'b00;
    localparam logic [1:0] IMM_SRC_MEM   = 2'b01;
    localparam logic [1:0] IMM_SRC_SHAMT = 2'b10;

    localparam int unsigned IMM_W  = 12;
    localparam int unsigned IMM8_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SEARCH = 2'b01,
        S_DONE   = 2'b10
    } state_e;

    // True when a candidate fits entirely in the low imm8 byte.
    function automatic logic fits_imm8(input logic [31:0] cand);
        return cand[31:IMM8_W] == '0;
    endfunction

endpackage

// File: rtl/immediate_encoder_rotate_left_32.sv
// Combinational 32-bit rotate-left by a 5-bit amount.
module rotate_left_32 (
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    output logic [31:0] result
);

    logic [63:0] doubled;

    // The upper half of the shifted doubled word is the rotation; amt == 0 gives data.
    always_comb begin
        doubled = {data, data} << amt;
        result  = doubled[63:32];
    end

endmodule

// File: rtl/immediate_encoder.sv
// Multi-cycle search for the 12-bit immediate field that expands back to a 32-bit constant.
// Data-processing constants try one even rotation per clock, lowest rotation first.
module immediate_encoder
    import immediate_encoder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] value_in,
    input  logic [1:0]            imm_src,
    output logic                  busy,
    output logic                  done,
    output logic                  encodable,
    output logic [IMM_W-1:0]      immediate_output
);

    localparam logic [ROT_W-1:0] ROT_LAST = '1;

    state_e                  state_q, state_d;
    logic [ROT_W-1:0]        rot_q, rot_d;
    logic [DATA_WIDTH-1:0]   value_q, value_d;
    logic [1:0]              src_q, src_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    enc_q, enc_d;
    logic [IMM_W-1:0]        imm_q, imm_d;
    logic [DATA_WIDTH-1:0]   cand;

    rotate_left_32 u_rotate (
        .data   (value_q),
        .amt    ({rot_q, 1'b0}),
        .result (cand)
    );

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        value_d = value_q;
        src_d   = src_q;
        enc_d   = enc_q;
        imm_d   = imm_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    value_d = value_in;
                    src_d   = imm_src;
                    rot_d   = '0;
                    state_d = S_SEARCH;
                    busy_d  = 1'b1;
                end
            end
            S_SEARCH: begin
                busy_d = 1'b1;
                unique case (src_q)
                    IMM_SRC_DP: begin
                        if (fits_imm8(cand)) begin
                            enc_d   = 1'b1;
                            imm_d   = {rot_q, cand[IMM8_W-1:0]};
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else if (rot_q == ROT_LAST) begin
                            enc_d   = 1'b0;
                            imm_d   = '0;
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            rot_d = rot_q + 1'b1;
                        end
                    end
                    IMM_SRC_MEM: begin
                        enc_d   = (value_q[DATA_WIDTH-1:12] == '0);
                        imm_d   = enc_d ? value_q[11:0] : '0;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                    IMM_SRC_SHAMT, 2'b11: begin
                        // shamt lives in field bits [11:7], as the extender decodes it
                        enc_d   = (value_q[DATA_WIDTH-1:5] == '0);
                        imm_d   = enc_d ? {value_q[4:0], 7'b0} : '0;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_DONE;
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rot_q   <= '0;
            value_q <= '0;
            src_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            enc_q   <= 1'b0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            value_q <= value_d;
            src_q   <= src_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            enc_q   <= enc_d;
            imm_q   <= imm_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign encodable        = enc_q;
    assign immediate_output = imm_q;

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed bench for immediate_encoder: latency, result, round-trip, abort and ignore cases.
module tb_immediate_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value_in = '0;
    logic [1:0]  imm_src = '0;
    logic        busy;
    logic        done;
    logic        encodable;
    logic [11:0] immediate_output;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    immediate_encoder dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .value_in         (value_in),
        .imm_src          (imm_src),
        .busy             (busy),
        .done             (done),
        .encodable        (encodable),
        .immediate_output (immediate_output)
    );

    // Reference immediate extender.
    function automatic logic [31:0] ext(input logic [1:0] s, input logic [11:0] f);
        logic [63:0] d;
        logic [5:0]  amt;
        case (s)
            2'b00: begin
                amt = {1'b0, f[11:8], 1'b0};
                d   = {24'b0, f[7:0], 24'b0, f[7:0]} >> amt;
                return d[31:0];
            end
            2'b01:   return {20'b0, f};
            default: return {27'b0, f[11:7]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] src, input logic [31:0] val,
                       input int exp_lat, input logic exp_enc, input logic [11:0] exp_out,
                       input int poke_at);
        int lat;
        lat = 0;
        @(negedge clk);
        start    = 1'b1;
        imm_src  = src;
        value_in = val;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = (c == poke_at);
            if (c == poke_at) begin
                value_in = 32'h0000_00FF;
                imm_src  = 2'b00;
            end else begin
                value_in = $urandom();
                imm_src  = 2'($urandom_range(0, 3));
            end
            if (c < 3) check({tag, " busy"}, 32'(busy), 32'd1);
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " encodable"}, 32'(encodable), 32'(exp_enc));
        check({tag, " imm"}, 32'(immediate_output), 32'(exp_out));
        if (exp_enc) check({tag, " roundtrip"}, ext(src, immediate_output), val);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, " post done"}, 32'(done), 32'd0);
        end
        check({tag, " post busy"}, 32'(busy), 32'd0);
        check({tag, " held"}, 32'(immediate_output), 32'(exp_out));
    endtask

    initial begin
        int seen;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset enc", 32'(encodable), 32'd0);
        check("reset imm", 32'(immediate_output), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run("dp 000000FF", 2'b00, 32'h0000_00FF, 2, 1'b1, 12'h0FF, 0);
        run("dp FF000000", 2'b00, 32'hFF00_0000, 6, 1'b1, 12'h4FF, 0);
        run("dp F000000F", 2'b00, 32'hF000_000F, 4, 1'b1, 12'h2FF, 0);

        // Reset mid-search aborts with no done pulse.
        @(negedge clk);
        start    = 1'b1;
        imm_src  = 2'b00;
        value_in = 32'h0000_0102;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        check("abort busy before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort enc", 32'(encodable), 32'd0);
        check("abort imm", 32'(immediate_output), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort no done", seen, 0);
        run("after abort", 2'b00, 32'h0000_00FF, 2, 1'b1, 12'h0FF, 0);

        run("dp 00000102", 2'b00, 32'h0000_0102, 17, 1'b0, 12'h000, 0);
        run("dp zero", 2'b00, 32'h0000_0000, 2, 1'b1, 12'h000, 0);
        run("mem ABC", 2'b01, 32'h0000_0ABC, 2, 1'b1, 12'hABC, 0);
        run("mem 1000", 2'b01, 32'h0000_1000, 2, 1'b0, 12'h000, 0);
        run("shamt 31", 2'b10, 32'd31, 2, 1'b1, 12'hF80, 0);
        run("shamt 32", 2'b11, 32'd32, 2, 1'b0, 12'h000, 0);
        run("busy start", 2'b00, 32'h0000_0102, 17, 1'b0, 12'h000, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
